// File: rtl/mips_shift_pkg.sv
// Shared definitions for the shift unit and the iterative normalizer:
// the normalizer state encoding and the shift-op codes used by both consumers.
package mips_shift_pkg;

  typedef enum logic [1:0] {
    NS_IDLE  = 2'd0,
    NS_SHIFT = 2'd1,
    NS_DONE  = 2'd2
  } norm_state_t;

  typedef enum logic [1:0] {
    SOP_SLL = 2'b00,
    SOP_SRL = 2'b01,
    SOP_SRA = 2'b10,
    SOP_ROT = 2'b11
  } shift_op_t;

endpackage

// File: rtl/mips_norm_detect.sv
// Combinational detector for the normalizer. It flags a zero working value.
// It also flags a value that needs no further left shift: the MSB is set in
// unsigned mode, or the top two bits differ in signed mode.
module mips_norm_detect #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] w,
  input  logic             signed_mode,
  output logic             is_zero,
  output logic             is_norm
);

  // Zero test and mode-dependent normalization test on the current value
  always_comb begin
    is_zero = (w == '0);
    if (signed_mode) begin
      is_norm = w[WIDTH-1] ^ w[WIDTH-2];
    end else begin
      is_norm = w[WIDTH-1];
    end
  end

endmodule

// File: rtl/mips_norm_seq.sv
// Iterative normalizer. It accepts one operand, then shifts it left one bit
// per cycle until it is normalized, and reports the shift count. The result is
// held under a valid/ready handshake, and only one operand is in flight at a time.
module mips_norm_seq
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AMT_W-1:0] out_amount,
  output logic             out_zero
);

  norm_state_t      state;
  logic [WIDTH-1:0] w;
  logic             signed_mode;
  logic [AMT_W-1:0] count;
  logic             is_zero;
  logic             is_norm;

  mips_norm_detect #(
    .WIDTH(WIDTH)
  ) u_detect (
    .w          (w),
    .signed_mode(signed_mode),
    .is_zero    (is_zero),
    .is_norm    (is_norm)
  );

  // Operands are accepted only while idle, and never while reset is held
  assign in_ready = (state == NS_IDLE) && rst_n;

  // Control FSM plus working and result registers.
  // On its first DONE cycle the FSM raises out_valid. It then waits for the consumer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= NS_IDLE;
      w           <= '0;
      signed_mode <= 1'b0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_amount  <= '0;
      out_zero    <= 1'b0;
    end else begin
      case (state)
        NS_IDLE: begin
          if (in_valid && in_ready) begin
            w           <= in_data;
            signed_mode <= in_signed;
            count       <= '0;
            state       <= NS_SHIFT;
          end
        end
        NS_SHIFT: begin
          if (is_zero) begin
            out_zero   <= 1'b1;
            out_data   <= '0;
            out_amount <= '0;
            state      <= NS_DONE;
          end else if (is_norm) begin
            out_zero   <= 1'b0;
            out_data   <= w;
            out_amount <= count;
            state      <= NS_DONE;
          end else begin
            w     <= w << 1;
            count <= count + 1'b1;
          end
        end
        NS_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= NS_IDLE;
          end
        end
        default: begin
          state     <= NS_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_norm_seq.sv
// Directed bench for the iterative normalizer with hand-computed results,
// latencies, backpressure and mid-operation reset.
module tb_mips_norm_seq;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AMT_W-1:0] out_amount;
  logic             out_zero;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mips_norm_seq #(
    .WIDTH(WIDTH),
    .AMT_W(AMT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_amount(out_amount),
    .out_zero  (out_zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called just after a falling edge. It offers one operand and measures the
  // number of rising edges from acceptance until out_valid.
  // With out_ready high, it also checks the handshake cycle.
  task automatic applyStimulus(input string tag, input logic [7:0] data, input logic sgn,
                               input logic [7:0] exp_data, input logic [2:0] exp_amt,
                               input logic exp_zero, input int exp_lat);
    int lat;
    checkOutput({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = data;
    in_signed = sgn;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput({tag, " latency"}, lat, exp_lat);
    checkOutput({tag, " data"}, {24'd0, out_data}, {24'd0, exp_data});
    checkOutput({tag, " amount"}, {29'd0, out_amount}, {29'd0, exp_amt});
    checkOutput({tag, " zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
    if (out_ready === 1'b1) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
      checkOutput({tag, " ready back"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset out_data", {24'd0, out_data}, 32'd0);
    checkOutput("reset out_amount", {29'd0, out_amount}, 32'd0);
    checkOutput("reset out_zero", {31'd0, out_zero}, 32'd0);
    rst_n = 1'b1;
    #1;

    applyStimulus("u01", 8'h01, 1'b0, 8'h80, 3'd7, 1'b0, 9);
    applyStimulus("u80", 8'h80, 1'b0, 8'h80, 3'd0, 1'b0, 2);
    applyStimulus("s40", 8'h40, 1'b1, 8'h40, 3'd0, 1'b0, 2);
    applyStimulus("sF0", 8'hF0, 1'b1, 8'h80, 3'd3, 1'b0, 5);
    applyStimulus("sFF", 8'hFF, 1'b1, 8'h80, 3'd7, 1'b0, 9);
    applyStimulus("u13", 8'h13, 1'b0, 8'h98, 3'd3, 1'b0, 5);
    applyStimulus("s01", 8'h01, 1'b1, 8'h40, 3'd6, 1'b0, 8);
    applyStimulus("u00", 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 2);
    applyStimulus("s00", 8'h00, 1'b1, 8'h00, 3'd0, 1'b1, 2);

    // Backpressure: the result must hold and a concurrent offer must be ignored
    out_ready = 1'b0;
    applyStimulus("bp u13", 8'h13, 1'b0, 8'h98, 3'd3, 1'b0, 5);
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'h01;
      in_signed = 1'b0;
      #1;
      checkOutput("bp in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp data", {24'd0, out_data}, 32'h98);
      checkOutput("bp amount", {29'd0, out_amount}, 32'd3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp handshake valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp handshake ready", {31'd0, in_ready}, 32'd1);
    applyStimulus("bp u01", 8'h01, 1'b0, 8'h80, 3'd7, 1'b0, 9);

    // Reset pulse at T+4 while 0x01 is still shifting
    in_valid  = 1'b1;
    in_data   = 8'h01;
    in_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst in_ready low", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst out_amount", {29'd0, out_amount}, 32'd0);
    checkOutput("rst in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checkOutput("rst no output", seen, 0);
    applyStimulus("rst u20", 8'h20, 1'b0, 8'h80, 3'd2, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
